// File: rtl/riscv_uop_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_uop_pkg
//  Brief    : Shared micro-op types and write-back source encoding.
//  Revision : 1.0
// ============================================================================
package riscv_uop_pkg;

    localparam int c_XLEN = 32;

    typedef struct packed {
        logic [5:0] rob_idx;
        logic [4:0] rd;
        logic       rd_we;
    } uop_t;

    typedef enum logic {
        WB_SRC_ALU = 1'b0,
        WB_SRC_LSU = 1'b1
    } wb_src_e;

endpackage
`default_nettype wire

// File: rtl/wb_src_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : wb_src_fifo
//  Brief    : Per-source completion FIFO with head read-out and flush.
//  Revision : 1.0
// ============================================================================
module wb_src_fifo #(
    parameter  int DEPTH   = 2,
    parameter  int WIDTH   = 32,
    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int c_CNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_flush,
    input  logic               i_push,
    input  logic [WIDTH-1:0]   i_data,
    input  logic               i_pop,
    output logic [WIDTH-1:0]   o_head,
    output logic [c_CNT_W-1:0] o_count,
    output logic               o_empty
);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_push;
    logic               w_pop;

    // A full FIFO refuses a push even when it is popping in the same cycle.
    assign w_push = i_push && !i_flush && (r_count != c_CNT_W'(DEPTH));
    assign w_pop  = i_pop  && !i_flush && (r_count != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_empty = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : wb_arbiter
//  Brief    : ALU/LSU write-back arbiter with starvation guard and stall lock.
//  Revision : 1.0
// ============================================================================
module wb_arbiter
    import riscv_uop_pkg::*;
#(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_alu_valid,
    input  uop_t        i_alu_uop,
    input  logic [31:0] i_alu_result,
    output logic        o_alu_ready,
    input  logic        i_lsu_valid,
    input  uop_t        i_lsu_uop,
    input  logic [31:0] i_lsu_load_data,
    output logic        o_lsu_ready,
    input  logic        i_flush,
    input  logic        i_stall,
    output logic        o_valid,
    output uop_t        o_uop,
    output logic [31:0] o_result,
    output wb_src_e     o_src
);

    localparam int c_ENT_W    = $bits(uop_t) + c_XLEN;
    localparam int c_CNT_W    = $clog2(DEPTH + 1);
    localparam int c_STARVE_W = $clog2(STARVE_MAX + 1);

    logic [c_ENT_W-1:0]    w_alu_head, w_lsu_head, w_head;
    logic [c_CNT_W-1:0]    w_alu_count, w_lsu_count;
    logic                  w_alu_empty, w_lsu_empty;
    logic                  w_alu_pop, w_lsu_pop, w_pop;
    wb_src_e               w_grant_free, w_grant;
    logic [c_STARVE_W-1:0] r_starve_cnt;
    logic                  r_lock;
    wb_src_e               r_lock_src;

    assign o_alu_ready = (w_alu_count < c_CNT_W'(DEPTH)) && !i_flush && rst_n;
    assign o_lsu_ready = (w_lsu_count < c_CNT_W'(DEPTH)) && !i_flush && rst_n;

    wb_src_fifo #(.DEPTH(DEPTH), .WIDTH(c_ENT_W)) u_alu_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (i_flush),
        .i_push  (i_alu_valid && o_alu_ready),
        .i_data  ({i_alu_uop, i_alu_result}),
        .i_pop   (w_alu_pop),
        .o_head  (w_alu_head),
        .o_count (w_alu_count),
        .o_empty (w_alu_empty)
    );

    wb_src_fifo #(.DEPTH(DEPTH), .WIDTH(c_ENT_W)) u_lsu_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (i_flush),
        .i_push  (i_lsu_valid && o_lsu_ready),
        .i_data  ({i_lsu_uop, i_lsu_load_data}),
        .i_pop   (w_lsu_pop),
        .o_head  (w_lsu_head),
        .o_count (w_lsu_count),
        .o_empty (w_lsu_empty)
    );

    // LSU normally wins; a waiting ALU entry is forced through once starved.
    always_comb begin
        w_grant_free = WB_SRC_ALU;
        if (!w_alu_empty && (r_starve_cnt == c_STARVE_W'(STARVE_MAX)))
            w_grant_free = WB_SRC_ALU;
        else if (!w_lsu_empty)
            w_grant_free = WB_SRC_LSU;
    end

    assign w_grant   = r_lock ? r_lock_src : w_grant_free;
    assign o_valid   = (!w_alu_empty || !w_lsu_empty) && !i_flush;
    assign w_pop     = o_valid && !i_stall;
    assign w_alu_pop = w_pop && (w_grant == WB_SRC_ALU);
    assign w_lsu_pop = w_pop && (w_grant == WB_SRC_LSU);

    assign w_head   = (w_grant == WB_SRC_LSU) ? w_lsu_head : w_alu_head;
    assign o_uop    = uop_t'(w_head[c_ENT_W-1:c_XLEN]);
    assign o_result = w_head[c_XLEN-1:0];
    assign o_src    = w_grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve_cnt <= '0;
            r_lock       <= 1'b0;
            r_lock_src   <= WB_SRC_ALU;
        end else if (i_flush) begin
            r_starve_cnt <= '0;
            r_lock       <= 1'b0;
        end else begin
            if (w_alu_pop)
                r_starve_cnt <= '0;
            else if (w_lsu_pop && !w_alu_empty &&
                     (r_starve_cnt != c_STARVE_W'(STARVE_MAX)))
                r_starve_cnt <= r_starve_cnt + c_STARVE_W'(1);

            // Hold the offered source steady until retire takes it.
            if (w_pop) begin
                r_lock <= 1'b0;
            end else if (o_valid) begin
                r_lock     <= 1'b1;
                r_lock_src <= w_grant;
            end
        end
    end

endmodule
`default_nettype wire
